seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter: the stimulus-side counterpart of the FSM sequence detector.

---
 rtl/seq_pattern_tx.sv | 153 +++++++++++++++
 tb/tb_seq_pattern_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a parallel pattern and shifts it out MSB-first,
// repeating it for a programmable number of passes with an idle gap between passes.
module seq_pattern_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned REP_W      = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [WIDTH-1:0]             load_data,
  input  logic [$clog2(WIDTH+1)-1:0]   load_len,
  input  logic [REP_W-1:0]             load_reps,
  input  logic                         abort,
  output logic                         ser_out,
  output logic                         ser_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned LEN_W  = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W  = $clog2(WIDTH);
  localparam int unsigned PASS_W = REP_W + 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [IDX_W-1:0]   len_m1;
  logic [IDX_W-1:0]   bit_idx;
  logic [PASS_W-1:0]  passes;
  logic [GAP_W-1:0]   gap_cnt;

  logic [IDX_W-1:0]   len_m1_c;
  logic [IDX_W-1:0]   idx_dec_c;

  // Effective pattern length minus one; 0 or out-of-range lengths mean a full-width pattern
  always_comb begin
    len_m1_c = IDX_W'(WIDTH - 1);
    if (load_len != '0 && load_len <= LEN_W'(WIDTH)) begin
      len_m1_c = IDX_W'(load_len - LEN_W'(1));
    end
    idx_dec_c = bit_idx - IDX_W'(1);
  end

  // Transmit FSM with registered serial, handshake and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      len_m1     <= '0;
      bit_idx    <= '0;
      passes     <= '0;
      gap_cnt    <= '0;
      ser_out    <= IDLE_LEVEL;
      ser_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else if (abort && state != S_IDLE) begin
      // Abort wins over everything else outside IDLE; the transfer is dropped silently
      state      <= S_IDLE;
      bit_idx    <= '0;
      passes     <= '0;
      gap_cnt    <= '0;
      ser_out    <= IDLE_LEVEL;
      ser_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_valid) begin
            shreg      <= load_data;
            len_m1     <= len_m1_c;
            bit_idx    <= len_m1_c;
            passes     <= PASS_W'(load_reps) + PASS_W'(1);
            ser_out    <= load_data[len_m1_c];
            ser_valid  <= 1'b1;
            busy       <= 1'b1;
            load_ready <= 1'b0;
            state      <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (bit_idx != '0) begin
            bit_idx <= idx_dec_c;
            ser_out <= shreg[idx_dec_c];
          end else if (passes == PASS_W'(1)) begin
            // Final bit of final pass has been held; emit the done pulse
            passes    <= '0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            passes <= passes - PASS_W'(1);
            if (GAP_CYCLES == 0) begin
              // Back-to-back passes: restart at the MSB with no bubble
              bit_idx <= len_m1;
              ser_out <= shreg[len_m1];
            end else begin
              gap_cnt   <= GAP_W'(GAP_CYCLES - 1);
              ser_out   <= IDLE_LEVEL;
              ser_valid <= 1'b0;
              state     <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            bit_idx   <= len_m1;
            ser_out   <= shreg[len_m1];
            ser_valid <= 1'b1;
            state     <= S_SHIFT;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        S_DONE: begin
          bit_idx    <= '0;
          gap_cnt    <= '0;
          done       <= 1'b0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
          state      <= S_IDLE;
        end

        default: begin
          state      <= S_IDLE;
          ser_out    <= IDLE_LEVEL;
          ser_valid  <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a gapped and a gapless instance share stimulus; the serial
// stream of each is rendered as a string ('1'/'0' bit, '-' idle gap, 'D' done) and compared.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic [3:0] load_len;
  logic [3:0] load_reps;
  logic       abort;

  logic ser_out, ser_valid, busy, done, load_ready;
  logic g0_ser_out, g0_ser_valid, g0_busy, g0_done, g0_load_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Loopback detector on the gapped instance: counts occurrences of 1011
  logic [3:0] hist = '0;
  int         det_cnt = 0;

  seq_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .load_reps(load_reps), .abort(abort),
    .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done));

  seq_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_dut_g0 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(g0_load_ready),
    .load_data(load_data), .load_len(load_len), .load_reps(load_reps), .abort(abort),
    .ser_out(g0_ser_out), .ser_valid(g0_ser_valid), .busy(g0_busy), .done(g0_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ser_valid) begin
      hist = {hist[2:0], ser_out};
      if (hist == 4'b1011) det_cnt++;
    end else begin
      hist = '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] reps;
    logic       poke;
  } vec_t;

  localparam int NV = 9;
  vec_t  vecs  [NV];
  string exp_g2[NV];
  string exp_g0[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic string sym(input logic so, input logic v, input logic d);
    if (d && !v && so == 1'b0) return "D";
    if (v && !d) return so ? "1" : "0";
    if (!v && !d && so == 1'b0) return "-";
    return "X";
  endfunction

  task automatic load(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
    @(negedge clk);
    load_data  = d;
    load_len   = l;
    load_reps  = r;
    load_valid = 1'b1;
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v, input string e2, input string e0);
    string s2, s0, t;
    logic  f2, f0;
    s2 = "";
    s0 = "";
    f2 = 1'b0;
    f0 = 1'b0;
    load(v.data, v.len, v.reps);
    for (int c = 0; c < 64 && !(f2 && f0); c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk({name, " busy_first"}, 32'(busy), 32'd1);
        chk({name, " ready_first"}, 32'(load_ready), 32'd0);
      end
      if (!f2) begin
        t  = sym(ser_out, ser_valid, done);
        s2 = {s2, t};
        f2 = (t == "D");
      end
      if (!f0) begin
        t  = sym(g0_ser_out, g0_ser_valid, g0_done);
        s0 = {s0, t};
        f0 = (t == "D");
      end
      // Mid-shift load attempt with new data: must not disturb the transfer
      if (v.poke && c == 2) begin
        load_valid = 1'b1;
        load_data  = 8'hFF;
        load_len   = 4'd1;
      end
      if (v.poke && c == 3) load_valid = 1'b0;
    end
    chk_s({name, " stream_gap2"}, s2, e2);
    chk_s({name, " stream_gap0"}, s0, e0);
    @(negedge clk);
    chk({name, " ready_after"}, 32'(load_ready), 32'd1);
    chk({name, " g0_ready_after"}, 32'(g0_load_ready), 32'd1);
    chk({name, " busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen;
    int   det0;

    vecs[0] = '{8'h0D, 4'd4,  4'd0, 1'b0}; exp_g2[0] = "1101D";          exp_g0[0] = "1101D";
    vecs[1] = '{8'h04, 4'd3,  4'd2, 1'b0}; exp_g2[1] = "100--100--100D"; exp_g0[1] = "100100100D";
    vecs[2] = '{8'h02, 4'd2,  4'd1, 1'b0}; exp_g2[2] = "10--10D";        exp_g0[2] = "1010D";
    vecs[3] = '{8'hA5, 4'd0,  4'd0, 1'b1}; exp_g2[3] = "10100101D";      exp_g0[3] = "10100101D";
    vecs[4] = '{8'h01, 4'd1,  4'd1, 1'b0}; exp_g2[4] = "1--1D";          exp_g0[4] = "11D";
    vecs[5] = '{8'h81, 4'd15, 4'd0, 1'b0}; exp_g2[5] = "10000001D";      exp_g0[5] = "10000001D";
    vecs[6] = '{8'hF0, 4'd5,  4'd0, 1'b0}; exp_g2[6] = "10000D";         exp_g0[6] = "10000D";
    vecs[7] = '{8'h01, 4'd2,  4'd1, 1'b0}; exp_g2[7] = "01--01D";        exp_g0[7] = "0101D";
    vecs[8] = '{8'h00, 4'd8,  4'd0, 1'b0}; exp_g2[8] = "00000000D";      exp_g0[8] = "00000000D";

    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    load_reps  = '0;
    abort      = 1'b0;

    // Reset values, during and just after reset
    repeat (3) @(negedge clk);
    chk("rst ser_out",    32'(ser_out),    32'd0);
    chk("rst ser_valid",  32'(ser_valid),  32'd0);
    chk("rst done",       32'(done),       32'd0);
    chk("rst busy",       32'(busy),       32'd0);
    chk("rst load_ready", 32'(load_ready), 32'd1);
    chk("rst g0_ready",   32'(g0_load_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst ready", 32'(load_ready), 32'd1);
    chk("post_rst valid", 32'(ser_valid),  32'd0);

    // Table-driven transfers
    for (int i = 0; i < NV; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], exp_g2[i], exp_g0[i]);
    end

    // Loopback into a 1011 detector: one hit per pass
    det0 = det_cnt;
    run_vec("loopback", '{8'h2C, 4'd8, 4'd2, 1'b0},
            "00101100--00101100--00101100D", "001011000010110000101100D");
    chk("loopback det_hits", 32'(det_cnt - det0), 32'd3);

    // Abort on the second bit of an 8-bit load
    load(8'hB3, 4'd8, 4'd0);
    @(negedge clk);
    chk("abort bit1", 32'(ser_out), 32'd1);
    @(negedge clk);
    chk("abort bit2", 32'({ser_valid, ser_out}), 32'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort ser_out", 32'(ser_out),    32'd0);
    chk("abort valid",   32'(ser_valid),  32'd0);
    chk("abort ready",   32'(load_ready), 32'd1);
    chk("abort busy",    32'(busy),       32'd0);
    chk("abort g0_valid", 32'(g0_ser_valid), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || ser_valid) seen = 1'b1;
    end
    chk("abort no_done", 32'(seen), 32'd0);

    // Abort during the inter-pass gap
    load(8'h04, 4'd3, 4'd2);
    repeat (4) @(negedge clk);
    chk("gap_abort in_gap", 32'({busy, ser_valid}), 32'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("gap_abort ready", 32'(load_ready), 32'd1);
    chk("gap_abort busy",  32'(busy),       32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || ser_valid) seen = 1'b1;
    end
    chk("gap_abort quiet", 32'(seen), 32'd0);

    // Abort is ignored in IDLE, so a simultaneous load is accepted
    @(negedge clk);
    abort      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h80;
    load_len   = 4'd8;
    load_reps  = 4'd0;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    abort      = 1'b0;
    @(negedge clk);
    chk("idle_abort load", 32'({ser_valid, ser_out}), 32'b11);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort stop", 32'(ser_valid), 32'd0);

    // Asynchronous reset mid-transfer
    load(8'hFF, 4'd8, 4'd3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst ser_out", 32'(ser_out),    32'd0);
    chk("mid_rst valid",   32'(ser_valid),  32'd0);
    chk("mid_rst ready",   32'(load_ready), 32'd1);
    chk("mid_rst busy",    32'(busy),       32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst stays_idle", 32'({busy, ser_valid, done}), 32'd0);

    // Recovery: a fresh transfer after reset works normally
    run_vec("after_rst", '{8'h0D, 4'd4, 4'd0, 1'b0}, "1101D", "1101D");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
